// File: rtl/adder_slice_sched_if.sv
// adder_slice_sched_if
// Bundles the handshake and bus signals of the wide-add scheduler:
//   req0_* / req1_*  : two requester ports (valid/ready, operands a/b, carry-in)
//   sl_*             : shared external 3-bit slice (operands out, sum/carry back)
//   resp_*           : result port (valid/ready, full sum, carry-out, requester id)
// The scheduler connects through the slave modport; the environment that
// issues requests, hosts the slice and consumes results uses master.
interface adder_slice_sched_if #(
  parameter int WIDTH = 12
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;

  logic [2:0]       sl_a;
  logic [2:0]       sl_b;
  logic             sl_cin;
  logic [2:0]       sl_sum;
  logic             sl_cout;

  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_sum;
  logic             resp_cout;
  logic             resp_id;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cin,
    output req1_ready,
    output sl_a, sl_b, sl_cin,
    input  sl_sum, sl_cout,
    output resp_valid, resp_sum, resp_cout, resp_id,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cin,
    input  req1_ready,
    input  sl_a, sl_b, sl_cin,
    output sl_sum, sl_cout,
    input  resp_valid, resp_sum, resp_cout, resp_id,
    output resp_ready
  );
endinterface

// File: rtl/adder_slice_sched.sv
// adder_slice_sched
// Serialises wide additions from two round-robin requesters through one
// shared external 3-bit ripple slice, LSB chunk first, chaining the carry
// through a local register, and returns {cout, sum} on a valid/ready port.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : adder_slice_sched_if.slave (requesters, slice, response)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; arbitration and ready are live here
// RUN   | one slice chunk per cycle, k = 0..CHUNKS-1
// DONE  | result presented on resp_*, held until resp_ready
module adder_slice_sched #(
  parameter int WIDTH = 12,
  parameter int CW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_slice_sched_if.slave   bus
);

  localparam int CHUNKS = WIDTH / 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cin_reg;
  logic             carry;
  logic             cout_reg;
  logic             id_reg;
  logic             last_grant;
  logic [CW-1:0]    k;

  logic             grant;
  logic             accept;
  logic             last_chunk;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;

  // Current chunk brought down to bit 0 so the slice sees bits [3k+2:3k].
  assign a_sh = a_reg >> (3 * k);
  assign b_sh = b_reg >> (3 * k);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    accept          = 1'b0;
    grant           = 1'b0;
    last_chunk      = (k == CW'(CHUNKS - 1));
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.sl_a        = 3'd0;
    bus.sl_b        = 3'd0;
    bus.sl_cin      = 1'b0;
    bus.resp_valid  = 1'b0;

    // Round-robin only matters under contention; a lone requester always wins.
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = bus.req1_valid;
    end

    case (state)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          accept         = 1'b1;
          bus.req0_ready = ~grant;
          bus.req1_ready = grant;
          state_nxt      = RUN;
        end
      end
      RUN: begin
        bus.sl_a   = a_sh[2:0];
        bus.sl_b   = b_sh[2:0];
        bus.sl_cin = (k == '0) ? cin_reg : carry;
        if (last_chunk) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
      cin_reg    <= 1'b0;
      carry      <= 1'b0;
      cout_reg   <= 1'b0;
      id_reg     <= 1'b0;
      last_grant <= 1'b1;
      k          <= '0;
    end else begin
      if (accept) begin
        a_reg      <= grant ? bus.req1_a   : bus.req0_a;
        b_reg      <= grant ? bus.req1_b   : bus.req0_b;
        cin_reg    <= grant ? bus.req1_cin : bus.req0_cin;
        id_reg     <= grant;
        last_grant <= grant;
        k          <= '0;
      end
      if (state == RUN) begin
        sum_reg[3*k +: 3] <= bus.sl_sum;
        carry             <= bus.sl_cout;
        if (last_chunk) begin
          cout_reg <= bus.sl_cout;
          k        <= '0;
        end else begin
          k <= k + CW'(1);
        end
      end
    end
  end

  assign bus.resp_sum  = sum_reg;
  assign bus.resp_cout = cout_reg;
  assign bus.resp_id   = id_reg;

endmodule
